hps_rst_sequencer: RTL and testbench
====================================

Name: hps_rst_sequencer

Overview:
Reset conditioning stage for the Arria V HPS subsystem. It takes the raw HPS-to-fabric reset and a software reset request, then synchronises, stretches and sequences them. It drives a single clean active-low fabric reset. That reset feeds the LUT keep-cell, which carries it unmodified to the fabric reset tree. A quiesce handshake lets downstream masters finish bus traffic before a software-initiated reset.

Parameters:
SYNC_STAGES, 3, synchroniser depth for deassertion of the async reset; legal range 2..8.
HOLD_CYCLES, 16, number of clk_i cycles rst_n_o is held low after reset sources clear; legal range 1..65535.
QUIESCE_TIMEOUT, 255, maximum cycles to wait for quiesce_ack_i; 0 = wait forever; legal range 0..65535.

Ports:
clk_i  in  1  fabric clock (h2f user clock).
rst_n_i  in  1  asynchronous active-low system reset.
hps_rst_n_i  in  1  asynchronous active-low reset from HPS (h2f_rst_n); no timing relation to clk_i.
sw_rst_req_i  in  1  synchronous single-cycle software reset request.
quiesce_ack_i  in  1  synchronous level: downstream is idle and ready for reset.
quiesce_req_o  out  1  level: request downstream to quiesce.
rst_n_o  out  1  conditioned active-low fabric reset; this is the input to the keep-cell.
rst_done_o  out  1  single-cycle pulse on each reset release.
timeout_o  out  1  single-cycle pulse when a quiesce wait expired without ack.
busy_o  out  1  high whenever state is not RUN.

Behaviour:
- Combined async reset: arst_n = rst_n_i AND hps_rst_n_i.
- While arst_n is low:
  - all flops are asynchronously cleared;
  - state = RESET;
  - rst_n_o = 0, quiesce_req_o = 0, rst_done_o = 0, timeout_o = 0, busy_o = 1.
- Assertion of rst_n_o is immediate (combinational path from arst_n through the flop clear). It occurs mid-operation from any state, including QUIESCE.
- Deassertion of arst_n:
  - a SYNC_STAGES-deep chain, async-cleared, shifts in 1;
  - the FSM leaves RESET only when the chain output is 1.
- States:
  - RESET: the chain output going 1 moves to HOLD, and the hold counter loads HOLD_CYCLES-1.
  - HOLD: rst_n_o = 0. The counter decrements each cycle; at 0 the FSM goes to RUN.
  - RUN: rst_n_o = 1, busy_o = 0. sw_rst_req_i = 1 moves to QUIESCE and the timeout counter clears.
  - QUIESCE: quiesce_req_o = 1 and rst_n_o stays 1. The FSM exits to HOLD when either condition holds:
    - quiesce_ack_i = 1;
    - QUIESCE_TIMEOUT != 0 and the counter reaches QUIESCE_TIMEOUT-1 (i.e. QUIESCE_TIMEOUT cycles in QUIESCE).
    On exit, the hold counter reloads HOLD_CYCLES-1. A timeout exit also pulses timeout_o for 1 cycle.
- All outputs are registered. Timing, counted from the first rising edge at which arst_n is high (edge 1):
  - RESET to HOLD at edge SYNC_STAGES+1;
  - rst_n_o rises at edge SYNC_STAGES+1+HOLD_CYCLES;
  - rst_done_o is high for exactly the first cycle rst_n_o is high.
- Software path timing:
  - sw_rst_req_i sampled at edge n gives quiesce_req_o = 1 after edge n;
  - ack sampled at edge m gives rst_n_o = 0 and quiesce_req_o = 0 after edge m (synchronous assert);
  - rst_n_o rises again HOLD_CYCLES edges later, with an rst_done_o pulse.
- Ignore rules and priorities:
  - sw_rst_req_i is ignored in RESET, HOLD and QUIESCE; requests are not queued.
  - quiesce_ack_i is ignored outside QUIESCE.
  - Ack and timeout in the same cycle: ack wins, no timeout_o pulse.
- Counter widths: hold counter 16 bit, timeout counter 16 bit; neither wraps (each saturates at its exit condition).
- hps_rst_n_i glitches shorter than one cycle still reset everything (the assert path is async). Release always takes the full SYNC_STAGES+HOLD_CYCLES sequence.

Test Plan:
1. Power-up, defaults: rst_n_i and hps_rst_n_i both release at edge 1 -> rst_n_o rises after edge 20 (3+1+16), rst_done_o high for that cycle only, busy_o falls at the same edge.
2. Software reset with ack: in RUN, pulse sw_rst_req_i at edge 100, hold quiesce_ack_i high from edge 105 -> quiesce_req_o high cycles 101..105, rst_n_o low after edge 105, rst_n_o high after edge 121, rst_done_o pulse, timeout_o never high.
3. Quiesce timeout: set QUIESCE_TIMEOUT=8, no ack, sw_rst_req_i at edge 50 -> timeout_o pulse and rst_n_o low after edge 58; release 16 cycles later.
4. Async reset mid-quiesce: drive hps_rst_n_i low for 3 ns inside QUIESCE -> rst_n_o and quiesce_req_o drop within the same cycle without a clock edge; full power-up sequence follows.
5. Ignore and priority rules: pulse sw_rst_req_i during HOLD -> no effect; assert ack and timeout in the same cycle (QUIESCE_TIMEOUT=4, ack on 4th cycle) -> no timeout_o; QUIESCE_TIMEOUT=0 with no ack for 10000 cycles -> stays in QUIESCE.
6. Parameter corners: SYNC_STAGES=2, HOLD_CYCLES=1 -> rst_n_o rises after edge 4 from release.

Source files
------------

// File: rtl/hps_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hps_rst_sequencer
// Purpose  : Reset conditioning for the HPS-to-fabric boundary. Combines the
//            system reset and the raw HPS reset into one asynchronous assert /
//            synchronous release source. It stretches the release by a
//            programmable hold time and sequences software-requested resets
//            behind a quiesce handshake with an optional timeout.
// Ports    : clk_i          fabric clock (h2f user clock)
//            rst_n_i        async active-low system reset
//            hps_rst_n_i    async active-low HPS reset (h2f_rst_n)
//            sw_rst_req_i   single-cycle software reset request
//            quiesce_ack_i  downstream idle / ready for reset (level)
//            quiesce_req_o  request downstream to quiesce (level)
//            rst_n_o        conditioned active-low fabric reset (to keep-cell)
//            rst_done_o     one-cycle pulse on each reset release
//            timeout_o      one-cycle pulse when a quiesce wait expired
//            busy_o         high whenever the sequencer is not in RUN
// Revision : 1.0 - initial release
// ============================================================================
module hps_rst_sequencer #(
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned QUIESCE_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic hps_rst_n_i,
    input  logic sw_rst_req_i,
    input  logic quiesce_ack_i,
    output logic quiesce_req_o,
    output logic rst_n_o,
    output logic rst_done_o,
    output logic timeout_o,
    output logic busy_o
);

    localparam logic [15:0] C_HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] C_TMO_LAST  = 16'(QUIESCE_TIMEOUT - 1);
    localparam bit          C_TMO_EN    = (QUIESCE_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_QUIESCE = 2'd3
    } state_t;

    // Either source asserts reset immediately; release is synchronised below.
    logic w_arst_n;
    assign w_arst_n = rst_n_i & hps_rst_n_i;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_hold_cnt;
    logic [15:0]            w_hold_cnt_nxt;
    logic [15:0]            r_tmo_cnt;
    logic [15:0]            w_tmo_cnt_nxt;
    logic                   w_tmo_pulse;

    logic r_rst_n;
    logic r_quiesce_req;
    logic r_rst_done;
    logic r_timeout;
    logic r_busy;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Release synchroniser: cleared asynchronously, fills with ones afterwards.
    always_ff @(posedge clk_i or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_state    <= ST_RESET;
            r_hold_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_tmo_pulse    = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (w_sync_out) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = C_HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == 16'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 16'd1;
                end
            end
            ST_RUN: begin
                if (sw_rst_req_i) begin
                    w_state_nxt   = ST_QUIESCE;
                    w_tmo_cnt_nxt = '0;
                end
            end
            ST_QUIESCE: begin
                // Ack is tested first so a coincident timeout is suppressed.
                if (quiesce_ack_i) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = C_HOLD_LOAD;
                end else if (C_TMO_EN && (r_tmo_cnt == C_TMO_LAST)) begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = C_HOLD_LOAD;
                    w_tmo_pulse    = 1'b1;
                end else if (C_TMO_EN) begin
                    // Stops at C_TMO_LAST, so it never wraps; frozen when
                    // the timeout is disabled.
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register; the async clear gives the immediate assert path.
    always_ff @(posedge clk_i or negedge w_arst_n) begin
        if (!w_arst_n) begin
            r_rst_n       <= 1'b0;
            r_quiesce_req <= 1'b0;
            r_rst_done    <= 1'b0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_rst_n       <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_QUIESCE);
            r_quiesce_req <= (w_state_nxt == ST_QUIESCE);
            r_rst_done    <= (r_state == ST_HOLD) && (w_state_nxt == ST_RUN);
            r_timeout     <= w_tmo_pulse;
            r_busy        <= (w_state_nxt != ST_RUN);
        end
    end

    assign rst_n_o       = r_rst_n;
    assign quiesce_req_o = r_quiesce_req;
    assign rst_done_o    = r_rst_done;
    assign timeout_o     = r_timeout;
    assign busy_o        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hps_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_rst_sequencer
// Purpose  : Self-checking bench for hps_rst_sequencer. Three instances with
//            different parameter sets share one stimulus stream; an
//            event-time reference model predicts every output of each.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_rst_sequencer;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       hps_rst_n_i;
    logic       sw_rst_req_i;
    logic       quiesce_ack_i;
    logic [2:0] quiesce_req_o;
    logic [2:0] rst_n_o;
    logic [2:0] rst_done_o;
    logic [2:0] timeout_o;
    logic [2:0] busy_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Parameter sets of the three instances (sync depth, hold, timeout).
    int p_sync[NDUT] = '{3, 2, 3};
    int p_hold[NDUT] = '{16, 1, 16};
    int p_qto[NDUT]  = '{8, 4, 0};

    // Reference model: tracks up/quiesce levels and the edge at which the
    // reset is due to release, rather than any counter or state encoding.
    bit m_started[NDUT];
    bit m_up[NDUT];
    bit m_q[NDUT];
    bit m_done[NDUT];
    bit m_tmo[NDUT];
    int m_rise[NDUT];
    int m_qstart[NDUT];

    always #5 clk = ~clk;

    hps_rst_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(16), .QUIESCE_TIMEOUT(8)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n_i), .hps_rst_n_i(hps_rst_n_i),
        .sw_rst_req_i(sw_rst_req_i), .quiesce_ack_i(quiesce_ack_i),
        .quiesce_req_o(quiesce_req_o[0]), .rst_n_o(rst_n_o[0]),
        .rst_done_o(rst_done_o[0]), .timeout_o(timeout_o[0]), .busy_o(busy_o[0])
    );

    hps_rst_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .QUIESCE_TIMEOUT(4)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n_i), .hps_rst_n_i(hps_rst_n_i),
        .sw_rst_req_i(sw_rst_req_i), .quiesce_ack_i(quiesce_ack_i),
        .quiesce_req_o(quiesce_req_o[1]), .rst_n_o(rst_n_o[1]),
        .rst_done_o(rst_done_o[1]), .timeout_o(timeout_o[1]), .busy_o(busy_o[1])
    );

    hps_rst_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(16), .QUIESCE_TIMEOUT(0)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n_i), .hps_rst_n_i(hps_rst_n_i),
        .sw_rst_req_i(sw_rst_req_i), .quiesce_ack_i(quiesce_ack_i),
        .quiesce_req_o(quiesce_req_o[2]), .rst_n_o(rst_n_o[2]),
        .rst_done_o(rst_done_o[2]), .timeout_o(timeout_o[2]), .busy_o(busy_o[2])
    );

    // {rst_n, quiesce_req, rst_done, timeout, busy}
    function automatic logic [4:0] obs(int k);
        return {rst_n_o[k], quiesce_req_o[k], rst_done_o[k], timeout_o[k], busy_o[k]};
    endfunction

    function automatic logic [4:0] expv(int k);
        return {m_up[k], m_q[k], m_done[k], m_tmo[k], !(m_up[k] && !m_q[k])};
    endfunction

    task automatic model_reset_all();
        for (int k = 0; k < NDUT; k++) begin
            m_started[k] = 0; m_up[k] = 0; m_q[k] = 0;
            m_done[k] = 0; m_tmo[k] = 0; m_rise[k] = -1; m_qstart[k] = 0;
        end
    endtask

    // One rising edge as seen by the model, decided from pre-edge levels.
    task automatic model_edge(int k);
        m_done[k] = 0;
        m_tmo[k]  = 0;
        if (!(rst_n_i && hps_rst_n_i)) begin
            m_started[k] = 0; m_up[k] = 0; m_q[k] = 0; m_rise[k] = -1;
        end else if (!m_started[k]) begin
            m_started[k] = 1;
            m_rise[k]    = cyc + p_sync[k] + p_hold[k];
        end else if (m_up[k] && !m_q[k]) begin
            if (sw_rst_req_i) begin
                m_q[k] = 1; m_qstart[k] = cyc;
            end
        end else if (m_q[k]) begin
            if (quiesce_ack_i) begin
                m_q[k] = 0; m_up[k] = 0; m_rise[k] = cyc + p_hold[k];
            end else if (p_qto[k] != 0 && (cyc - m_qstart[k]) == p_qto[k]) begin
                m_q[k] = 0; m_up[k] = 0; m_tmo[k] = 1; m_rise[k] = cyc + p_hold[k];
            end
        end else if (cyc == m_rise[k]) begin
            m_up[k] = 1; m_done[k] = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NDUT; k++) model_edge(k);
        #1;
    endtask

    task automatic run_idle(int n);
        sw_rst_req_i  = 1'b0;
        quiesce_ack_i = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b1; hps_rst_n_i = 1'b1; sw_rst_req_i = 1'b0; quiesce_ack_i = 1'b0;
        model_reset_all();
        #1;
        rst_n_i = 1'b0; hps_rst_n_i = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs(k) !== 5'b00001) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b want %b", k, obs(k), 5'b00001);
            end
        end
        for (int i = 0; i < 3; i++) begin
            sw_rst_req_i = 1'b1;
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL reset_hold dut%0d cyc %0d got %b want %b", k, cyc, obs(k), expv(k));
                end
            end
        end
        sw_rst_req_i = 1'b0;
    endtask

    task automatic test_power_up();
        rst_n_i = 1'b1; hps_rst_n_i = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL pwr_model dut%0d edge %0d got %b want %b", k, i, obs(k), expv(k));
                end
            end
            if (i == 19 || i == 20 || i == 21) begin
                checks++;
                if ({rst_n_o[0], rst_done_o[0], busy_o[0]} !== ((i == 19) ? 3'b001 : (i == 20) ? 3'b110 : 3'b100)) begin
                    errors++;
                    $display("FAIL pwr_dut0 edge %0d got %b", i, {rst_n_o[0], rst_done_o[0], busy_o[0]});
                end
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (rst_n_o[1] !== (i == 4)) begin
                    errors++;
                    $display("FAIL pwr_corner_dut1 edge %0d got %b want %b", i, rst_n_o[1], i == 4);
                end
            end
        end
    endtask

    task automatic test_sw_ack();
        run_idle(30);
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        checks++;
        if (quiesce_req_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL ack_qreq_rise got %b want 1", quiesce_req_o[0]);
        end
        for (int i = 1; i <= 25; i++) begin
            quiesce_ack_i = (i >= 5 && i <= 7);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL ack_model dut%0d edge +%0d got %b want %b", k, i, obs(k), expv(k));
                end
            end
            if (i == 4 || i == 5) begin
                checks++;
                if ({rst_n_o[0], quiesce_req_o[0]} !== ((i == 4) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL ack_dut0 edge +%0d got %b", i, {rst_n_o[0], quiesce_req_o[0]});
                end
            end
            if (i == 21) begin
                checks++;
                if ({rst_n_o[0], rst_done_o[0], timeout_o[0]} !== 3'b110) begin
                    errors++;
                    $display("FAIL ack_release got %b want 110", {rst_n_o[0], rst_done_o[0], timeout_o[0]});
                end
            end
        end
        quiesce_ack_i = 1'b0;
    endtask

    task automatic test_timeout();
        run_idle(30);
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL tmo_model dut%0d edge +%0d got %b want %b", k, i, obs(k), expv(k));
                end
            end
            if (i == 8 || i == 9) begin
                checks++;
                if ({timeout_o[0], rst_n_o[0]} !== ((i == 8) ? 2'b10 : 2'b00)) begin
                    errors++;
                    $display("FAIL tmo_dut0 edge +%0d got %b", i, {timeout_o[0], rst_n_o[0]});
                end
            end
            if (i == 4) begin
                checks++;
                if (timeout_o[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_dut1 got %b want 1", timeout_o[1]);
                end
            end
            if (i == 24) begin
                checks++;
                if ({rst_n_o[0], rst_done_o[0]} !== 2'b11) begin
                    errors++;
                    $display("FAIL tmo_release got %b want 11", {rst_n_o[0], rst_done_o[0]});
                end
            end
        end
    endtask

    task automatic test_priority();
        run_idle(30);
        sw_rst_req_i = 1'b1;
        tick();
        for (int i = 1; i <= 30; i++) begin
            quiesce_ack_i = (i == 4);
            sw_rst_req_i  = (i == 6);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL prio_model dut%0d edge +%0d got %b want %b", k, i, obs(k), expv(k));
                end
            end
            if (i == 4) begin
                checks++;
                if ({timeout_o[1], rst_n_o[1]} !== 2'b00) begin
                    errors++;
                    $display("FAIL prio_ack_wins got %b want 00", {timeout_o[1], rst_n_o[1]});
                end
            end
            if (i == 6) begin
                checks++;
                if ({quiesce_req_o[0], rst_n_o[0]} !== 2'b00) begin
                    errors++;
                    $display("FAIL prio_sw_in_hold got %b want 00", {quiesce_req_o[0], rst_n_o[0]});
                end
            end
        end
        sw_rst_req_i  = 1'b0;
        quiesce_ack_i = 1'b0;
    endtask

    task automatic test_async_quiesce();
        run_idle(30);
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({rst_n_o[0], quiesce_req_o[0]} !== 2'b11) begin
            errors++;
            $display("FAIL async_pre got %b want 11", {rst_n_o[0], quiesce_req_o[0]});
        end
        hps_rst_n_i = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs(k) !== 5'b00001) begin
                errors++;
                $display("FAIL async_glitch dut%0d got %b want 00001", k, obs(k));
            end
        end
        #2;
        hps_rst_n_i = 1'b1;
        model_reset_all();
        for (int i = 1; i <= 22; i++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL async_model dut%0d edge %0d got %b want %b", k, i, obs(k), expv(k));
                end
            end
            if (i == 19 || i == 20) begin
                checks++;
                if (rst_n_o[0] !== (i == 20)) begin
                    errors++;
                    $display("FAIL async_release edge %0d got %b want %b", i, rst_n_o[0], i == 20);
                end
            end
        end
    endtask

    task automatic test_wait_forever();
        run_idle(30);
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 1; i <= 10000; i++) begin
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL forever_model dut%0d edge +%0d got %b want %b", k, i, obs(k), expv(k));
                end
            end
        end
        checks++;
        if ({rst_n_o[2], quiesce_req_o[2], busy_o[2], timeout_o[2]} !== 4'b1110) begin
            errors++;
            $display("FAIL forever_hold got %b want 1110", {rst_n_o[2], quiesce_req_o[2], busy_o[2], timeout_o[2]});
        end
        quiesce_ack_i = 1'b1;
        tick();
        quiesce_ack_i = 1'b0;
        checks++;
        if ({rst_n_o[2], quiesce_req_o[2]} !== 2'b00) begin
            errors++;
            $display("FAIL forever_ack got %b want 00", {rst_n_o[2], quiesce_req_o[2]});
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r             = int'($urandom_range(0, 999));
            sw_rst_req_i  = ($urandom_range(0, 7) == 0);
            quiesce_ack_i = ($urandom_range(0, 3) == 0);
            if (r < 4) begin
                hps_rst_n_i = 1'b0;
                #2;
                hps_rst_n_i = 1'b1;
                model_reset_all();
            end
            rst_n_i = !(r >= 4 && r < 8);
            tick();
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL rand_model dut%0d cyc %0d got %b want %b", k, cyc, obs(k), expv(k));
                end
            end
        end
        rst_n_i       = 1'b1;
        sw_rst_req_i  = 1'b0;
        quiesce_ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_ack();
        test_timeout();
        test_priority();
        test_async_quiesce();
        test_wait_forever();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
